// File: rtl/ee194_core_top.sv
// JTAG-controlled UART transmitter with GFSK frequency-code ramp; TCK sampled through synchronisers, bytes written while busy are dropped (sticky overflow).
// Optional scan chain and config register enabled by `define EE194_SCANCHAIN_EN; default build ties SCAN_OUT low and fixes the GFSK center at 3'b100.
module ee194_core_top #(
    parameter logic [31:0] IDCODE   = 32'h1000_0CA3,
    parameter int          UART_DIV = 174
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_jtag_TCK,
    input  logic       io_jtag_TMS,
    input  logic       io_jtag_TDI,
    input  logic       io_jtag_TRSTn,
    output logic       io_jtag_TDO,
    output logic       io_uart_txd,
    input  logic       io_uart_rxd,
    output logic [2:0] io_gfskout,
    input  logic       io_scanchain_PHI,
    input  logic       io_scanchain_PHIB,
    input  logic       io_scanchain_i0o1,
    input  logic       io_scanchain_LOAD,
    input  logic       io_scanchain_SCAN_IN,
    output logic       io_scanchain_SCAN_OUT,
    input  logic       io_gpio_pins_0_i_ival,
    input  logic       io_gpio_pins_1_i_ival,
    input  logic       io_gpio_pins_2_i_ival,
    input  logic       io_gpio_pins_3_i_ival,
    input  logic       io_isig,
    input  logic       io_qsig,
    input  logic       io_alternate_modulation_in,
    input  logic       io_modulator_bypass_force,
    input  logic       io_enable_scan_global,
    input  logic       io_clock_40MHz
);
    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_UART   = 5'h10;
    localparam logic [4:0] IR_STATUS = 5'h11;
    localparam int         BAUD_W    = $clog2(UART_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(UART_DIV - 1);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_t;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            TLR:     n = tms ? TLR    : RTI;
            RTI:     n = tms ? SEL_DR : RTI;
            SEL_DR:  n = tms ? SEL_IR : CAP_DR;
            CAP_DR:  n = tms ? EX1_DR : SH_DR;
            SH_DR:   n = tms ? EX1_DR : SH_DR;
            EX1_DR:  n = tms ? UPD_DR : PAU_DR;
            PAU_DR:  n = tms ? EX2_DR : PAU_DR;
            EX2_DR:  n = tms ? UPD_DR : SH_DR;
            UPD_DR:  n = tms ? SEL_DR : RTI;
            SEL_IR:  n = tms ? TLR    : CAP_IR;
            CAP_IR:  n = tms ? EX1_IR : SH_IR;
            SH_IR:   n = tms ? EX1_IR : SH_IR;
            EX1_IR:  n = tms ? UPD_IR : PAU_IR;
            PAU_IR:  n = tms ? EX2_IR : PAU_IR;
            EX2_IR:  n = tms ? UPD_IR : SH_IR;
            UPD_IR:  n = tms ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

    logic [1:0] r_tck_s, r_tms_s, r_tdi_s, r_trstn_s, r_rxd_s;
    logic       r_tck_d;
    logic       w_tck_rise, w_tck_fall, w_tap_rst;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tck_s   <= 2'b00;
            r_tms_s   <= 2'b11;
            r_tdi_s   <= 2'b00;
            r_trstn_s <= 2'b11;
            r_rxd_s   <= 2'b11;
            r_tck_d   <= 1'b0;
        end else begin
            r_tck_s   <= {r_tck_s[0], io_jtag_TCK};
            r_tms_s   <= {r_tms_s[0], io_jtag_TMS};
            r_tdi_s   <= {r_tdi_s[0], io_jtag_TDI};
            r_trstn_s <= {r_trstn_s[0], io_jtag_TRSTn};
            r_rxd_s   <= {r_rxd_s[0], io_uart_rxd};
            r_tck_d   <= r_tck_s[1];
        end
    end

    assign w_tck_rise = r_tck_s[1] & ~r_tck_d;
    assign w_tck_fall = ~r_tck_s[1] & r_tck_d;
    assign w_tap_rst  = reset | ~r_trstn_s[1];

    tap_state_t  r_tap;
    logic [4:0]  r_ir, r_ir_sr;
    logic [31:0] r_dr, w_dr_cap, w_dr_shift;
    logic        r_tdo;
    logic        r_tx_busy, r_ovf;
    logic [9:0]  r_frame;

    always_comb begin
        w_dr_cap = 32'd0;
        case (r_ir)
            IR_IDCODE: w_dr_cap = IDCODE;
            IR_UART:   w_dr_cap = {31'd0, r_tx_busy};
            IR_STATUS: w_dr_cap = {24'd0, 1'b0, io_gpio_pins_3_i_ival, io_gpio_pins_2_i_ival,
                                   io_gpio_pins_1_i_ival, io_gpio_pins_0_i_ival,
                                   r_rxd_s[1], r_ovf, r_tx_busy};
            default:   w_dr_cap = 32'd0;
        endcase
    end

    // TDI enters the MSB of whichever register length the current instruction selects
    always_comb begin
        w_dr_shift = {1'b0, r_dr[31:1]};
        case (r_ir)
            IR_IDCODE:         w_dr_shift[31] = r_tdi_s[1];
            IR_UART, IR_STATUS: w_dr_shift[7] = r_tdi_s[1];
            default:           w_dr_shift[0]  = r_tdi_s[1];
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_tap_rst) begin
            r_tap   <= TLR;
            r_ir    <= IR_IDCODE;
            r_ir_sr <= 5'd0;
            r_dr    <= 32'd0;
            r_tdo   <= 1'b0;
        end else begin
            if (r_tap == TLR)
                r_ir <= IR_IDCODE;
            if (w_tck_rise) begin
                r_tap <= tap_next(r_tap, r_tms_s[1]);
                case (r_tap)
                    CAP_IR:  r_ir_sr <= 5'b00001;
                    SH_IR:   r_ir_sr <= {r_tdi_s[1], r_ir_sr[4:1]};
                    CAP_DR:  r_dr    <= w_dr_cap;
                    SH_DR:   r_dr    <= w_dr_shift;
                    default: ;
                endcase
            end
            if (w_tck_fall) begin
                r_tdo <= (r_tap == SH_IR) ? r_ir_sr[0] :
                         (r_tap == SH_DR) ? r_dr[0]    : 1'b0;
                if (r_tap == UPD_IR)
                    r_ir <= r_ir_sr;
            end
        end
    end

    assign io_jtag_TDO = r_tdo;

    logic w_uart_upd, w_stat_cap;
    assign w_uart_upd = w_tck_fall & ~w_tap_rst & (r_tap == UPD_DR) & (r_ir == IR_UART);
    assign w_stat_cap = w_tck_rise & ~w_tap_rst & (r_tap == CAP_DR) & (r_ir == IR_STATUS);

    logic [BAUD_W-1:0] r_baud;
    logic [3:0]        r_bitn;

    // r_frame[0] is the line level; ones fill in from the top so it idles high
    always_ff @(posedge clock) begin
        if (reset) begin
            r_frame   <= 10'h3FF;
            r_baud    <= '0;
            r_bitn    <= 4'd0;
            r_tx_busy <= 1'b0;
        end else if (r_tx_busy) begin
            if (r_baud == BAUD_LAST) begin
                r_baud  <= '0;
                r_frame <= {1'b1, r_frame[9:1]};
                if (r_bitn == 4'd9) begin
                    r_tx_busy <= 1'b0;
                    r_bitn    <= 4'd0;
                end else begin
                    r_bitn <= r_bitn + 4'd1;
                end
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end else if (w_uart_upd) begin
            r_frame   <= {1'b1, r_dr[7:0], 1'b0};
            r_baud    <= '0;
            r_bitn    <= 4'd0;
            r_tx_busy <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (w_uart_upd && r_tx_busy)
            r_ovf <= 1'b1;
        else if (w_stat_cap)
            r_ovf <= 1'b0;
    end

    assign io_uart_txd = r_frame[0];

    logic [2:0] w_center, w_target, r_gfsk;
    logic       w_unused;

`ifdef EE194_SCANCHAIN_EN
    logic [1:0] r_phi_s, r_phib_s;
    logic       r_phi_d;
    logic [7:0] r_scan_sr, r_scan_cfg;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_phi_s    <= 2'b00;
            r_phib_s   <= 2'b00;
            r_phi_d    <= 1'b0;
            r_scan_sr  <= 8'h04;
            r_scan_cfg <= 8'h04;
        end else begin
            r_phi_s  <= {r_phi_s[0], io_scanchain_PHI};
            r_phib_s <= {r_phib_s[0], io_scanchain_PHIB};
            r_phi_d  <= r_phi_s[1];
            if (io_enable_scan_global) begin
                if (io_scanchain_LOAD) begin
                    if (io_scanchain_i0o1)
                        r_scan_sr <= r_scan_cfg;
                    else
                        r_scan_cfg <= r_scan_sr;
                end else if (r_phi_s[1] && !r_phi_d && !r_phib_s[1]) begin
                    r_scan_sr <= {r_scan_sr[6:0], io_scanchain_SCAN_IN};
                end
            end
        end
    end

    assign io_scanchain_SCAN_OUT = r_scan_sr[7];
    assign w_center              = r_scan_cfg[2:0];
    assign w_unused              = ^{io_clock_40MHz, r_scan_cfg[7:3]};
`else
    assign io_scanchain_SCAN_OUT = 1'b0;
    assign w_center              = 3'b100;
    assign w_unused              = ^{io_clock_40MHz, io_scanchain_PHI, io_scanchain_PHIB,
                                     io_scanchain_i0o1, io_scanchain_LOAD,
                                     io_scanchain_SCAN_IN, io_enable_scan_global};
`endif

    assign w_target = r_tx_busy ? {3{r_frame[0]}} : w_center;

    always_ff @(posedge clock) begin
        if (reset)
            r_gfsk <= 3'b100;
        else if (io_modulator_bypass_force)
            r_gfsk <= {io_alternate_modulation_in, io_isig, io_qsig};
        else if (r_gfsk < w_target)
            r_gfsk <= r_gfsk + 3'd1;
        else if (r_gfsk > w_target)
            r_gfsk <= r_gfsk - 3'd1;
    end

    assign io_gfskout = r_gfsk;

endmodule

// File: tb/tb_ee194_core_top.sv
// Directed bench for ee194_core_top: JTAG IDCODE/IR/BYPASS, UART frame timing, overflow/status, GFSK ramp and bypass, TRST and reset behaviour.
module tb_ee194_core_top;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_jtag_TCK = 1'b0, io_jtag_TMS = 1'b1, io_jtag_TDI = 1'b0, io_jtag_TRSTn = 1'b1;
    logic       io_jtag_TDO, io_uart_txd;
    logic       io_uart_rxd = 1'b1;
    logic [2:0] io_gfskout;
    logic       io_scanchain_PHI = 1'b0, io_scanchain_PHIB = 1'b0, io_scanchain_i0o1 = 1'b0;
    logic       io_scanchain_LOAD = 1'b0, io_scanchain_SCAN_IN = 1'b0, io_scanchain_SCAN_OUT;
    logic       io_gpio_pins_0_i_ival = 1'b0, io_gpio_pins_1_i_ival = 1'b1;
    logic       io_gpio_pins_2_i_ival = 1'b0, io_gpio_pins_3_i_ival = 1'b1;
    logic       io_isig = 1'b0, io_qsig = 1'b0, io_alternate_modulation_in = 1'b0;
    logic       io_modulator_bypass_force = 1'b0, io_enable_scan_global = 1'b0;
    logic       io_clock_40MHz = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ee194_core_top dut (
        .clock(clock), .reset(reset),
        .io_jtag_TCK(io_jtag_TCK), .io_jtag_TMS(io_jtag_TMS), .io_jtag_TDI(io_jtag_TDI),
        .io_jtag_TRSTn(io_jtag_TRSTn), .io_jtag_TDO(io_jtag_TDO),
        .io_uart_txd(io_uart_txd), .io_uart_rxd(io_uart_rxd), .io_gfskout(io_gfskout),
        .io_scanchain_PHI(io_scanchain_PHI), .io_scanchain_PHIB(io_scanchain_PHIB),
        .io_scanchain_i0o1(io_scanchain_i0o1), .io_scanchain_LOAD(io_scanchain_LOAD),
        .io_scanchain_SCAN_IN(io_scanchain_SCAN_IN), .io_scanchain_SCAN_OUT(io_scanchain_SCAN_OUT),
        .io_gpio_pins_0_i_ival(io_gpio_pins_0_i_ival), .io_gpio_pins_1_i_ival(io_gpio_pins_1_i_ival),
        .io_gpio_pins_2_i_ival(io_gpio_pins_2_i_ival), .io_gpio_pins_3_i_ival(io_gpio_pins_3_i_ival),
        .io_isig(io_isig), .io_qsig(io_qsig),
        .io_alternate_modulation_in(io_alternate_modulation_in),
        .io_modulator_bypass_force(io_modulator_bypass_force),
        .io_enable_scan_global(io_enable_scan_global), .io_clock_40MHz(io_clock_40MHz)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One TCK period of 12 system clocks; TDO is sampled just before the rising edge
    task automatic tck(input logic tms, input logic tdi, output logic tdo);
        io_jtag_TMS = tms;
        io_jtag_TDI = tdi;
        clk(6);
        tdo = io_jtag_TDO;
        io_jtag_TCK = 1'b1;
        clk(6);
        io_jtag_TCK = 1'b0;
    endtask

    task automatic shift_ir(input logic [4:0] v, output logic [4:0] o);
        logic d;
        o = 5'd0;
        tck(1'b1, 1'b0, d); tck(1'b1, 1'b0, d); tck(1'b0, 1'b0, d); tck(1'b0, 1'b0, d);
        for (int i = 0; i < 5; i++) begin
            tck(i == 4, v[i], d);
            o[i] = d;
        end
        tck(1'b1, 1'b0, d); tck(1'b0, 1'b0, d);
    endtask

    task automatic shift_dr(input logic [31:0] v, input int n, output logic [31:0] o);
        logic d;
        o = 32'd0;
        tck(1'b1, 1'b0, d); tck(1'b0, 1'b0, d); tck(1'b0, 1'b0, d);
        for (int i = 0; i < n; i++) begin
            tck(i == n - 1, v[i], d);
            o[i] = d;
        end
        tck(1'b1, 1'b0, d); tck(1'b0, 1'b0, d);
    endtask

    // Finds the start bit, then checks the first and last clock of every bit period
    task automatic uart_mon(input logic [7:0] b, output logic [2:0] g0, output logic [2:0] g1);
        logic [9:0] f;
        logic       a;
        int         t;
        f  = {1'b1, b, 1'b0};
        g0 = 3'bxxx;
        g1 = 3'bxxx;
        t  = 0;
        while (io_uart_txd !== 1'b0 && t < 3000) begin
            clk(1);
            t++;
        end
        chk("uart_start_seen", 32'(t < 3000), 32'd1);
        for (int k = 0; k < 10; k++) begin
            a = io_uart_txd;
            for (int c = 1; c < 174; c++) begin
                clk(1);
                if (k == 0 && c == 2) g0 = io_gfskout;
                if (k == 1 && c == 3) g1 = io_gfskout;
            end
            chk($sformatf("uart_bit%0d", k), 32'({a, io_uart_txd}), 32'({f[k], f[k]}));
            clk(1);
        end
        chk("uart_idle_after_stop", 32'(io_uart_txd), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [31:0] o;
        logic [4:0]  o5;
        logic [2:0]  g0, g1;
        logic        d;
        logic [7:0]  sv;

        clk(50);
        chk("rst_tdo",      32'(io_jtag_TDO), 32'd0);
        chk("rst_txd",      32'(io_uart_txd), 32'd1);
        chk("rst_gfsk",     32'(io_gfskout), 32'd4);
        chk("rst_scan_out", 32'(io_scanchain_SCAN_OUT), 32'd0);
        reset = 1'b0;
        clk(5);

        for (int i = 0; i < 5; i++) tck(1'b1, 1'b0, d);
        tck(1'b0, 1'b0, d);
        shift_dr(32'd0, 32, o);
        chk("idcode", o, 32'h1000_0CA3);

        shift_ir(5'h10, o5);
        chk("ir_capture", 32'(o5), 32'd1);
        fork
            shift_dr(32'h41, 8, o);
            uart_mon(8'h41, g0, g1);
        join
        chk("uart_cap_idle", o, 32'd0);
        chk("gfsk_ramp_down", 32'(g0), 32'd2);
        chk("gfsk_ramp_up", 32'(g1), 32'd3);

        shift_dr(32'h55, 8, o);
        shift_dr(32'hAA, 8, o);
        chk("uart_cap_busy", o, 32'd1);
        shift_ir(5'h11, o5);
        shift_dr(32'd0, 8, o);
        chk("status_ovf_set", o, 32'h57);
        shift_dr(32'd0, 8, o);
        chk("status_ovf_clr", o, 32'h55);
        clk(2000);
        shift_dr(32'd0, 8, o);
        chk("status_idle", o, 32'h54);

        io_modulator_bypass_force = 1'b1;
        io_alternate_modulation_in = 1'b1;
        io_isig = 1'b0;
        io_qsig = 1'b1;
        clk(1);
        chk("gfsk_bypass", 32'(io_gfskout), 32'd5);
        io_modulator_bypass_force = 1'b0;
        clk(10);

        shift_ir(5'h1F, o5);
        shift_dr(32'h0B2, 9, o);
        chk("bypass_delay", o, 32'h164);

        shift_ir(5'h10, o5);
        shift_dr(32'h00, 8, o);
        tck(1'b1, 1'b0, d); tck(1'b0, 1'b0, d); tck(1'b0, 1'b0, d);
        for (int i = 0; i < 8; i++) tck(1'b0, 1'b1, d);
        clk(6);
        chk("pre_trst_tdo", 32'(io_jtag_TDO), 32'd1);
        io_jtag_TRSTn = 1'b0;
        clk(10);
        io_jtag_TRSTn = 1'b1;
        clk(4);
        chk("trst_tdo", 32'(io_jtag_TDO), 32'd0);
        chk("trst_frame_continues", 32'(io_uart_txd), 32'd0);
        tck(1'b0, 1'b0, d);
        shift_dr(32'd0, 32, o);
        chk("trst_idcode", o, 32'h1000_0CA3);

        clk(2000);
        shift_ir(5'h10, o5);
        shift_dr(32'h00, 8, o);
        clk(20);
        chk("frame_running", 32'(io_uart_txd), 32'd0);
        reset = 1'b1;
        clk(1);
        chk("rst_abort_txd", 32'(io_uart_txd), 32'd1);
        chk("rst_abort_gfsk", 32'(io_gfskout), 32'd4);
        clk(3);
        reset = 1'b0;
        clk(5);

        io_enable_scan_global = 1'b1;
        io_scanchain_PHIB = 1'b0;
        io_scanchain_LOAD = 1'b0;
        sv = 8'h07;
        for (int i = 7; i >= 0; i--) begin
            io_scanchain_SCAN_IN = sv[i];
            clk(4);
            io_scanchain_PHI = 1'b1;
            clk(4);
            io_scanchain_PHI = 1'b0;
        end
        io_scanchain_i0o1 = 1'b0;
        io_scanchain_LOAD = 1'b1;
        clk(2);
        io_scanchain_LOAD = 1'b0;
        io_scanchain_SCAN_IN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clk(4);
            io_scanchain_PHI = 1'b1;
            clk(4);
            io_scanchain_PHI = 1'b0;
        end
        clk(20);
`ifdef EE194_SCANCHAIN_EN
        chk("scan_gfsk_center", 32'(io_gfskout), 32'd7);
        chk("scan_out_bit7", 32'(io_scanchain_SCAN_OUT), 32'd1);
`else
        chk("noscan_gfsk_center", 32'(io_gfskout), 32'd4);
        chk("noscan_out_tied", 32'(io_scanchain_SCAN_OUT), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
